// File: rtl/iomem_timer.sv
// iomem_timer: countdown timer/interrupt responder on the picosoc iomem bus.
// Define IOMEM_TIMER_PRESCALE_EN to add the 16-bit PRESCALE register at offset 0x10.
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  localparam logic [5:0] RegCtrl   = 6'd0;
  localparam logic [5:0] RegLoad   = 6'd1;
  localparam logic [5:0] RegCount  = 6'd2;
  localparam logic [5:0] RegStatus = 6'd3;

  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic [2:0]  ctrl_q, ctrl_d;  // {irq_en, reload, enable}
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        expired_q, expired_d;

  logic [5:0]  word;
  logic        ack, wr, tick, expire;
  logic [31:0] rd_val, wr_val;
  logic        unused_addr;

`ifdef IOMEM_TIMER_PRESCALE_EN
  localparam logic [5:0] RegPrescale = 6'd4;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pcnt_q, pcnt_d;
`endif

  assign word        = iomem_addr[7:2];
  assign unused_addr = ^iomem_addr[1:0];
  // Never acknowledge two cycles in a row; the requester drops valid after ready.
  assign ack = iomem_valid & (iomem_addr[31:8] == BASE_ADDR[31:8]) & ~ready_q;
  assign wr  = ack & (|iomem_wstrb);

  always_comb begin
    rd_val = '0;
    case (word)
      RegCtrl:     rd_val = {29'd0, ctrl_q};
      RegLoad:     rd_val = load_q;
      RegCount:    rd_val = count_q;
      RegStatus:   rd_val = {31'd0, expired_q};
`ifdef IOMEM_TIMER_PRESCALE_EN
      RegPrescale: rd_val = {16'd0, prescale_q};
`endif
      default:     rd_val = '0;
    endcase
  end

  // Byte-lane merge of write data over the addressed register's current value.
  always_comb begin
    wr_val = rd_val;
    for (int i = 0; i < 4; i++) begin
      if (iomem_wstrb[i]) wr_val[8*i +: 8] = iomem_wdata[8*i +: 8];
    end
  end

`ifdef IOMEM_TIMER_PRESCALE_EN
  assign tick = ctrl_q[0] & (pcnt_q == prescale_q);

  always_comb begin
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    if (ctrl_q[0]) pcnt_d = (pcnt_q == prescale_q) ? 16'd0 : pcnt_q + 16'd1;
    if (wr && word == RegPrescale) prescale_d = wr_val[15:0];
    if (wr && (word == RegPrescale || word == RegCtrl)) pcnt_d = 16'd0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prescale_q <= 16'd0;
      pcnt_q     <= 16'd0;
    end else begin
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end
`else
  assign tick = ctrl_q[0];
`endif

  assign expire = tick & (count_q == 32'd0);

  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;

    if (tick) begin
      if (count_q != 32'd0) count_d = count_q - 32'd1;
      else if (ctrl_q[1])   count_d = load_q;
      else                  ctrl_d[0] = 1'b0;
    end

    // Bus writes are applied after the timer update so they take priority.
    if (wr) begin
      case (word)
        RegCtrl:   ctrl_d  = wr_val[2:0];
        RegLoad:   load_d  = wr_val;
        RegCount:  count_d = wr_val;
        RegStatus: if (iomem_wstrb[0] && iomem_wdata[0]) expired_d = 1'b0;
        default:   ;
      endcase
    end

    if (expire) expired_d = 1'b1;

    irq_d   = expired_d & ctrl_d[2];
    ready_d = ack;
    rdata_d = ack ? rd_val : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q   <= 1'b0;
      rdata_q   <= 32'd0;
      irq_q     <= 1'b0;
      ctrl_q    <= 3'd0;
      load_q    <= RESET_LOAD;
      count_q   <= 32'd0;
      expired_q <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_timer.sv
// Randomized self-checking bench for iomem_timer against an arithmetic model of
// the countdown (tick count -> COUNT/STATUS), bus timing and byte-lane writes.
module tb_iomem_timer;

  localparam logic [31:0] Base      = 32'h0300_0000;
  localparam logic [31:0] ResetLoad = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned last_ack;
  int          last_lat;
  logic [31:0] last_rd;
  int unsigned presc = 0;

  int unsigned c, l, p, t0, j, first_irq, w;
  logic [31:0] load_m, d, a;
  logic [3:0]  s;

  iomem_timer #(
    .BASE_ADDR (Base),
    .RESET_LOAD(ResetLoad)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(valid),
    .iomem_ready(ready),
    .iomem_wstrb(wstrb),
    .iomem_addr (addr),
    .iomem_wdata(wdata),
    .iomem_rdata(rdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at #1 after a clock edge; returns at #1 after the acknowledge edge.
  task automatic bus(input logic [31:0] ad, input logic [3:0] st, input logic [31:0] dt);
    valid    = 1'b1;
    addr     = ad;
    wstrb    = st;
    wdata    = dt;
    last_lat = -1;
    last_rd  = 32'd0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        last_lat = i;
        last_rd  = rdata;
        last_ack = cyc;
        break;
      end
    end
    valid = 1'b0;
    wstrb = 4'd0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dt);
    bus(Base | {24'd0, off}, 4'hF, dt);
    check_eq("wr_ack", 32'(last_lat > 0), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    bus(Base | {24'd0, off}, 4'h0, 32'd0);
    check_eq(tag, last_rd, exp);
  endtask

  task automatic set_presc(input int unsigned pv);
`ifdef IOMEM_TIMER_PRESCALE_EN
    presc = pv;
    wr(8'h10, pv);
`else
    presc = 0;
`endif
  endtask

  // COUNT after jj enabled edges: ticks = jj/(P+1); down from C, then period L+1.
  function automatic logic [31:0] model_count(int unsigned cc, int unsigned ll, int unsigned pp,
                                              int unsigned jj, bit rel);
    int unsigned n;
    n = jj / (pp + 1);
    if (n <= cc) return cc - n;
    if (!rel) return 32'd0;
    return ll - ((n - cc - 1) % (ll + 1));
  endfunction

  function automatic logic [31:0] model_expired(int unsigned cc, int unsigned pp, int unsigned jj);
    return 32'((jj / (pp + 1)) >= cc + 1);
  endfunction

  initial begin
    resetn = 1'b0;
    valid  = 1'b0;
    wstrb  = 4'd0;
    addr   = 32'd0;
    wdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Reset register values and single-cycle latency from idle.
    bus(Base, 4'h0, 32'd0);
    check_eq("lat_idle", last_lat, 32'd1);
    check_eq("rst_ctrl", last_rd, 32'd0);
    @(posedge clk);
    #1;
    check_eq("ready_one_cycle", 32'(ready), 32'd0);
    check_eq("rdata_idle", rdata, 32'd0);
    rd_chk("rst_load", 8'h04, ResetLoad);
    rd_chk("rst_count", 8'h08, 32'd0);
    rd_chk("rst_status", 8'h0C, 32'd0);
    rd_chk("rst_off10", 8'h10, 32'd0);

    // Byte-lane writes to LOAD.
    wr(8'h04, 32'd0);
    bus(Base | 32'h4, 4'b0010, 32'hAABB_CCDD);
    rd_chk("load_lane1", 8'h04, 32'h0000_CC00);
    load_m = 32'h0000_CC00;
    for (int it = 0; it < 6; it++) begin
      s = 4'($urandom_range(0, 15));
      d = $urandom;
      for (int b = 0; b < 4; b++) if (s[b]) load_m[8*b +: 8] = d[8*b +: 8];
      bus(Base | 32'h4, s, d);
      rd_chk("load_rand", 8'h04, load_m);
    end

    // Out-of-window requests are never acknowledged.
    bus(32'h0400_0000, 4'h0, 32'd0);
    check_eq("oow_fixed", last_lat, -1);
    for (int it = 0; it < 3; it++) begin
      a = $urandom;
      if (a[31:8] == Base[31:8]) a[31] = ~a[31];
      bus(a, 4'($urandom_range(0, 15)), $urandom);
      check_eq("oow_rand", last_lat, -1);
    end

    // Unused offsets read zero and ignore writes.
    for (int it = 0; it < 3; it++) begin
      w = $urandom_range(5, 63);
      wr(8'(w * 4), $urandom);
      rd_chk("unused_off", 8'(w * 4), 32'd0);
    end
`ifndef IOMEM_TIMER_PRESCALE_EN
    wr(8'h10, 32'hFFFF_FFFF);
    rd_chk("off10_nopresc", 8'h10, 32'd0);
`endif

    // Auto-reload: COUNT/STATUS sampled at random delays after enable.
    for (int it = 0; it < 5; it++) begin
      c = (it == 0) ? 5 : $urandom_range(0, 6);
      l = (it == 0) ? 5 : $urandom_range(0, 5);
      p = $urandom_range(0, 3);
      wr(8'h00, 32'd0);
      wr(8'h0C, 32'd1);
      set_presc(p);
      wr(8'h04, l);
      wr(8'h08, c);
      wr(8'h00, 32'd3);
      t0 = last_ack;
      repeat ($urandom_range(0, 25)) begin
        @(posedge clk);
        #1;
      end
      bus(Base | 32'h8, 4'h0, 32'd0);
      j = last_ack - t0 - 1;
      check_eq("reload_count", last_rd, model_count(c, l, presc, j, 1'b1));
      bus(Base | 32'hC, 4'h0, 32'd0);
      j = last_ack - t0 - 1;
      check_eq("reload_status", last_rd, model_expired(c, presc, j));
      rd_chk("reload_ctrl", 8'h00, 32'd3);
    end

    // One-shot with interrupt: irq edge timing, enable auto-clear, W1C.
    for (int it = 0; it < 4; it++) begin
      c = (it == 0) ? 2 : $urandom_range(0, 5);
`ifdef IOMEM_TIMER_PRESCALE_EN
      p = (it == 0) ? 3 : $urandom_range(0, 3);
`else
      p = 0;
`endif
      wr(8'h00, 32'd0);
      wr(8'h0C, 32'd1);
      set_presc(p);
      wr(8'h08, c);
      wr(8'h00, 32'd5);
      t0 = last_ack;
      first_irq = 0;
      for (int k = 0; k < (c + 2) * (presc + 1) + 4; k++) begin
        @(posedge clk);
        #1;
        if (irq && first_irq == 0) first_irq = cyc - t0;
      end
      check_eq("oneshot_irq_time", first_irq, (c + 1) * (presc + 1));
      rd_chk("oneshot_ctrl", 8'h00, 32'd4);
      rd_chk("oneshot_count", 8'h08, 32'd0);
      rd_chk("oneshot_status", 8'h0C, 32'd1);
      check_eq("irq_held", 32'(irq), 32'd1);
      wr(8'h0C, 32'd1);
      check_eq("irq_w1c", 32'(irq), 32'd0);
    end

    // Collisions at the expiry edge (two edges after the enabling write).
    set_presc(0);
    wr(8'h00, 32'd0);
    wr(8'h0C, 32'd1);
    wr(8'h08, 32'd1);
    wr(8'h00, 32'd1);
    t0 = last_ack;
    d = $urandom | 32'h100;
    wr(8'h08, d);
    check_eq("coll_count_time", last_ack - t0, 32'd2);
    rd_chk("coll_count_val", 8'h08, d);
    rd_chk("coll_count_status", 8'h0C, 32'd1);
    rd_chk("coll_count_ctrl", 8'h00, 32'd0);

    wr(8'h0C, 32'd1);
    rd_chk("w1c_clear", 8'h0C, 32'd0);
    wr(8'h08, 32'd1);
    wr(8'h00, 32'd1);
    t0 = last_ack;
    wr(8'h0C, 32'd1);
    check_eq("coll_w1c_time", last_ack - t0, 32'd2);
    rd_chk("coll_w1c_status", 8'h0C, 32'd1);

    wr(8'h04, 32'd3);
    wr(8'h08, 32'd1);
    wr(8'h00, 32'd1);
    t0 = last_ack;
    wr(8'h00, 32'd7);
    check_eq("coll_ctrl_time", last_ack - t0, 32'd2);
    rd_chk("coll_ctrl_val", 8'h00, 32'd7);

    // Reset coinciding with a write acknowledge discards the write.
    wr(8'h04, 32'h1234_5678);
    resetn = 1'b0;
    valid  = 1'b1;
    addr   = Base | 32'h8;
    wstrb  = 4'hF;
    wdata  = 32'h0000_00AA;
    @(posedge clk);
    #1;
    check_eq("rst_mid_ready", 32'(ready), 32'd0);
    valid  = 1'b0;
    wstrb  = 4'd0;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_irq", 32'(irq), 32'd0);
    rd_chk("rst_mid_count", 8'h08, 32'd0);
    rd_chk("rst_mid_load", 8'h04, ResetLoad);
    rd_chk("rst_mid_ctrl", 8'h00, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
